// File: rtl/mem_req_sender_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_sender_pkg
//   Shared memory-request definitions used by the request sender and the
//   downstream memory queue: request/line geometry, op encodings, legal
//   address window, sender FSM states and a request legality helper.
// ---------------------------------------------------------------------------
package mem_req_sender_pkg;

  // Request / line geometry
  localparam int MEM_REQUEST_SIZE   = 38;   // queue request word width
  localparam int MEM_ADDR_WIDTH     = 32;   // address width
  localparam int MEM_DATA_WIDTH     = 128;  // cache line width
  localparam int MEM_CYCLE_NUM_DATA = 4;    // data beats per line

  // Legal address window (inclusive on both ends)
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_BOUNDARY_UP  = 32'h0000_1FFF;
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_BOUNDARY_LOW = 32'h0000_0000;

  // Op encodings shared with the queue
  localparam logic [1:0] OP_RD      = 2'b00;
  localparam logic [1:0] OP_WR      = 2'b01;
  localparam logic [1:0] OP_PWB     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Sender FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BEAT = 2'd2,
    ST_GAP  = 2'd3
  } sender_state_e;

  // A request is legal when its op is defined and its address lies inside
  // [lo, hi]. The bounds are passed in so that a zero lower bound does not
  // turn the comparison into a constant expression.
  function automatic logic req_is_legal(
    input logic [1:0]                op,
    input logic [MEM_ADDR_WIDTH-1:0] addr,
    input logic [MEM_ADDR_WIDTH-1:0] lo,
    input logic [MEM_ADDR_WIDTH-1:0] hi
  );
    return (op != OP_ILLEGAL) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_req_sender.sv
// ---------------------------------------------------------------------------
// mem_req_sender
//   Takes one cache-side request at a time and serialises it into the memory
//   queue: a header word, then (for WR/PWB) CYCLE_NUM_DATA data beats on
//   consecutive cycles, then one idle GAP cycle. Illegal requests (bad op or
//   address outside the legal window) are rejected with an error pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (shared with the queue)
//   req_valid  in   cache side offers a request
//   req_ready  out  sender accepts a request this cycle (state == IDLE)
//   req_op     in   RD=00, WR=01, PWB=10, 11 illegal
//   req_addr   in   request address
//   req_data   in   line data (WR/PWB only)
//   q_full     in   queue full; only stalls the header
//   q_push_en  out  push strobe to the queue
//   q_op       out  op presented to the queue (00 whenever not pushing)
//   q_buf      out  header {pad, op, addr} or beat {pad, op, word}
//   sent_valid out  one-cycle pulse when a request is fully transmitted
//   err_valid  out  one-cycle pulse when a request is rejected
//   err_addr   out  address of the last rejected request
// ---------------------------------------------------------------------------
module mem_req_sender
  import mem_req_sender_pkg::*;
#(
  parameter int                    REQUEST_SIZE   = MEM_REQUEST_SIZE,
  parameter int                    ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int                    CYCLE_NUM_DATA = MEM_CYCLE_NUM_DATA,
  parameter logic [ADDR_WIDTH-1:0] BOUNDARY_UP    = MEM_BOUNDARY_UP,
  parameter logic [ADDR_WIDTH-1:0] BOUNDARY_LOW   = MEM_BOUNDARY_LOW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic                    q_full,
  output logic                    q_push_en,
  output logic [1:0]              q_op,
  output logic [REQUEST_SIZE-1:0] q_buf,
  output logic                    sent_valid,
  output logic                    err_valid,
  output logic [ADDR_WIDTH-1:0]   err_addr
);

  localparam int WORD_W  = DATA_WIDTH / CYCLE_NUM_DATA;
  localparam int CNT_W   = $clog2(CYCLE_NUM_DATA);
  localparam int HDR_PAD = REQUEST_SIZE - 2 - ADDR_WIDTH;
  localparam int BEAT_PAD = REQUEST_SIZE - 2 - WORD_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CYCLE_NUM_DATA - 1);

  sender_state_e          state_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [1:0]             op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   sent_valid_q;
  logic                   err_valid_q;
  logic [ADDR_WIDTH-1:0]  err_addr_q;

  logic                   accept;
  logic                   legal;

  // Beat words, most-significant word first: beat 0 carries data[127:96].
  logic [WORD_W-1:0]      words [CYCLE_NUM_DATA];
  logic [WORD_W-1:0]      beat_word;

  genvar gi;
  generate
    for (gi = 0; gi < CYCLE_NUM_DATA; gi++) begin : g_words
      assign words[gi] = data_q[DATA_WIDTH-1-gi*WORD_W -: WORD_W];
    end
  endgenerate

  assign beat_word = words[beat_cnt_q];

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign legal     = req_is_legal(req_op, req_addr, BOUNDARY_LOW, BOUNDARY_UP);

  // Main FSM. Captured op/addr/data only load while IDLE, so changes on the
  // request inputs during a burst cannot corrupt the words being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      op_q         <= OP_RD;
      addr_q       <= '0;
      data_q       <= '0;
      sent_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      sent_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            if (legal) begin
              state_q <= ST_HDR;
            end else begin
              err_valid_q <= 1'b1;
              err_addr_q  <= req_addr;
            end
          end
        end
        ST_HDR: begin
          // Header only leaves when the queue can take it; stall is unbounded.
          if (!q_full) begin
            if (op_q == OP_RD) begin
              state_q      <= ST_IDLE;
              sent_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_BEAT;
              beat_cnt_q <= '0;
            end
          end
        end
        ST_BEAT: begin
          // The queue counts beats by cycle, so q_full is not consulted here.
          beat_cnt_q <= beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One dead cycle lets the queue's data counter return to zero.
          state_q      <= ST_IDLE;
          sent_valid_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Queue-side outputs follow the state directly so the header goes out the
  // cycle after acceptance and reacts to q_full in the same cycle. Outside a
  // push, q_op is forced to 00 so the queue never sees a stray WR/PWB.
  always_comb begin
    q_push_en = 1'b0;
    q_op      = OP_RD;
    q_buf     = '0;
    case (state_q)
      ST_HDR: begin
        if (!q_full) begin
          q_push_en = 1'b1;
          q_op      = op_q;
          q_buf     = {{HDR_PAD{1'b0}}, op_q, addr_q};
        end
      end
      ST_BEAT: begin
        q_push_en = 1'b1;
        q_op      = op_q;
        q_buf     = {{BEAT_PAD{1'b0}}, op_q, beat_word};
      end
      default: begin
        q_push_en = 1'b0;
        q_op      = OP_RD;
        q_buf     = '0;
      end
    endcase
  end

  assign sent_valid = sent_valid_q;
  assign err_valid  = err_valid_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_mem_req_sender.sv
module tb_mem_req_sender;
  import mem_req_sender_pkg::*;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic         q_full;
  logic         q_push_en;
  logic [1:0]   q_op;
  logic [37:0]  q_buf;
  logic         sent_valid;
  logic         err_valid;
  logic [31:0]  err_addr;

  int tests = 0;
  int fails = 0;

  mem_req_sender dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .q_full     (q_full),
    .q_push_en  (q_push_en),
    .q_op       (q_op),
    .q_buf      (q_buf),
    .sent_valid (sent_valid),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         full;
    logic         e_ready;
    logic         e_push;
    logic [1:0]   e_op;
    logic [37:0]  e_buf;
    logic         e_sent;
    logic         e_err;
    logic [31:0]  e_eaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic valid, input logic [1:0] op, input logic [31:0] addr,
    input logic [127:0] data, input logic full,
    input logic e_ready, input logic e_push, input logic [1:0] e_op,
    input logic [37:0] e_buf, input logic e_sent, input logic e_err,
    input logic [31:0] e_eaddr);
    vec_t v;
    v.valid = valid; v.op = op; v.addr = addr; v.data = data; v.full = full;
    v.e_ready = e_ready; v.e_push = e_push; v.e_op = e_op; v.e_buf = e_buf;
    v.e_sent = e_sent; v.e_err = e_err; v.e_eaddr = e_eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bench-side model of the downstream queue: a header starts an entry, a
  // WR/PWB header is followed by four beats counted by cycle.
  logic         mon_en = 1'b0;
  int           beats_left = 0;
  logic [1:0]   cur_op;
  logic [31:0]  cur_addr;
  logic [127:0] cur_line;
  logic [1:0]   m_op[$];
  logic [31:0]  m_addr[$];
  logic [127:0] m_line[$];

  always begin
    @(negedge clk);
    #2;
    if (mon_en && q_push_en === 1'b1) begin
      if (beats_left == 0) begin
        cur_op   = q_op;
        cur_addr = q_buf[31:0];
        cur_line = '0;
        if (q_op == OP_RD) begin
          m_op.push_back(cur_op); m_addr.push_back(cur_addr); m_line.push_back(cur_line);
        end else begin
          beats_left = 4;
        end
      end else begin
        cur_line = {cur_line[95:0], q_buf[31:0]};
        beats_left--;
        if (beats_left == 0) begin
          m_op.push_back(cur_op); m_addr.push_back(cur_addr); m_line.push_back(cur_line);
        end
      end
    end
  end

  // Offer a request and hold it until accepted (bounded); returns at the
  // falling edge of the header cycle with req_valid dropped.
  task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input logic [127:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    #1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("accept_ready", {63'b0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    $display("[TB] sent op=%0d addr=%h", op, addr);
  endtask

  localparam logic [127:0] D_WR  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D_PWB = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] D_BAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D_F   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_data = '0; q_full = 1'b0;

    // RD 0x40: header the cycle after acceptance, sent pulse one later
    vecs.push_back(mk(1, OP_RD, 32'h40, '0, 0,  1, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, OP_RD, 32'h0,  '0, 0,  0, 1, 2'b00, 38'h00_0000_0040, 0, 0, 32'h0));
    vecs.push_back(mk(0, OP_RD, 32'h0,  '0, 0,  1, 0, 2'b00, 38'h0, 1, 0, 32'h0));
    // WR 0x100; inputs scrambled after acceptance must not matter
    vecs.push_back(mk(1, OP_WR, 32'h100, D_WR, 0,        1, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 32'hFFFF_FFFF, D_BAD, 0, 0, 1, 2'b01, 38'h1_0000_0100, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 32'hFFFF_FFFF, D_BAD, 0, 0, 1, 2'b01, 38'h1_1111_1111, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 32'hFFFF_FFFF, D_BAD, 0, 0, 1, 2'b01, 38'h1_2222_2222, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 32'hFFFF_FFFF, D_BAD, 0, 0, 1, 2'b01, 38'h1_3333_3333, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 32'hFFFF_FFFF, D_BAD, 0, 0, 1, 2'b01, 38'h1_4444_4444, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,            0, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,            1, 0, 2'b00, 38'h0, 1, 0, 32'h0));
    // PWB 0x200 stalled 3 cycles, then beats ignore q_full
    vecs.push_back(mk(1, OP_PWB, 32'h200, D_PWB, 0, 1, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 1,       0, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 1,       0, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 1,       0, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,       0, 1, 2'b10, 38'h2_0000_0200, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 1,       0, 1, 2'b10, 38'h2_AAAA_AAAA, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 1,       0, 1, 2'b10, 38'h2_BBBB_BBBB, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,       0, 1, 2'b10, 38'h2_CCCC_CCCC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,       0, 1, 2'b10, 38'h2_DDDD_DDDD, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,       0, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h0, '0, 0,       1, 0, 2'b00, 38'h0, 1, 0, 32'h0));
    // Rejections: RD above the window, then illegal op
    vecs.push_back(mk(1, OP_RD, 32'h2000, '0, 0, 1, 0, 2'b00, 38'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'b11, 32'h50,   '0, 0, 1, 0, 2'b00, 38'h0, 0, 1, 32'h2000));
    vecs.push_back(mk(0, 2'b00, 32'h0,    '0, 0, 1, 0, 2'b00, 38'h0, 0, 1, 32'h50));
    vecs.push_back(mk(0, 2'b00, 32'h0,    '0, 0, 1, 0, 2'b00, 38'h0, 0, 0, 32'h50));
    // Highest legal address is accepted
    vecs.push_back(mk(1, OP_RD, 32'h1FFF, '0, 0, 1, 0, 2'b00, 38'h0, 0, 0, 32'h50));
    vecs.push_back(mk(0, 2'b00, 32'h0,    '0, 0, 0, 1, 2'b00, 38'h00_0000_1FFF, 0, 0, 32'h50));
    vecs.push_back(mk(0, 2'b00, 32'h0,    '0, 0, 1, 0, 2'b00, 38'h0, 1, 0, 32'h50));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready",    {63'b0, req_ready},  64'd1);
    check("rst_push",     {63'b0, q_push_en},  64'd0);
    check("rst_qop",      {62'b0, q_op},       64'd0);
    check("rst_qbuf",     {26'b0, q_buf},      64'd0);
    check("rst_sent",     {63'b0, sent_valid}, 64'd0);
    check("rst_err",      {63'b0, err_valid},  64'd0);
    check("rst_err_addr", {32'b0, err_addr},   64'd0);
    rst = 1'b0;

    // Table-driven vectors, one row per cycle
    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].valid; req_op = vecs[i].op; req_addr = vecs[i].addr;
      req_data = vecs[i].data; q_full = vecs[i].full;
      #1;
      check($sformatf("v%0d_ready", i),    {63'b0, req_ready},  {63'b0, vecs[i].e_ready});
      check($sformatf("v%0d_push", i),     {63'b0, q_push_en},  {63'b0, vecs[i].e_push});
      check($sformatf("v%0d_qop", i),      {62'b0, q_op},       {62'b0, vecs[i].e_op});
      check($sformatf("v%0d_qbuf", i),     {26'b0, q_buf},      {26'b0, vecs[i].e_buf});
      check($sformatf("v%0d_sent", i),     {63'b0, sent_valid}, {63'b0, vecs[i].e_sent});
      check($sformatf("v%0d_err", i),      {63'b0, err_valid},  {63'b0, vecs[i].e_err});
      check($sformatf("v%0d_err_addr", i), {32'b0, err_addr},   {32'b0, vecs[i].e_eaddr});
      $display("[TB] vec %0d valid=%b op=%0d full=%b push=%b q_op=%0d q_buf=%h sent=%b err=%b",
               i, vecs[i].valid, vecs[i].op, vecs[i].full, q_push_en, q_op, q_buf, sent_valid, err_valid);
    end
    @(negedge clk);
    req_valid = 1'b0; q_full = 1'b0;

    // Reset during beat 2 of a WR aborts the burst
    send_req(OP_WR, 32'h180, D_F);
    repeat (3) @(negedge clk);
    #1;
    check("abort_beat2_buf", {26'b0, q_buf}, {26'b0, 38'h1_FEDC_BA98});
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_push",  {63'b0, q_push_en}, 64'd0);
    check("abort_ready", {63'b0, req_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_idle_push", {63'b0, q_push_en}, 64'd0);
    send_req(OP_RD, 32'h80, '0);
    #1;
    check("post_rst_push", {63'b0, q_push_en}, 64'd1);
    check("post_rst_buf",  {26'b0, q_buf},     {26'b0, 38'h00_0000_0080});
    @(negedge clk);
    #1;
    check("post_rst_sent", {63'b0, sent_valid}, 64'd1);

    // Back-to-back WR then RD through the queue model
    mon_en = 1'b1;
    send_req(OP_WR, 32'h300, D_F);
    send_req(OP_RD, 32'h340, '0);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check("q_count", 64'(m_op.size()), 64'd2);
    if (m_op.size() >= 2) begin
      check("q_pop0_op",   {62'b0, m_op[0]},    {62'b0, OP_WR});
      check("q_pop0_addr", {32'b0, m_addr[0]},  64'h300);
      check("q_pop0_hi",   m_line[0][127:64],   D_F[127:64]);
      check("q_pop0_lo",   m_line[0][63:0],     D_F[63:0]);
      check("q_pop1_op",   {62'b0, m_op[1]},    {62'b0, OP_RD});
      check("q_pop1_addr", {32'b0, m_addr[1]},  64'h340);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_req_sender.md
MEM_REQ_SENDER -- requirements
Module: mem_req_sender

Interface
REQ-001 Parameters SHALL be: REQUEST_SIZE 38 (queue request word width); ADDR_WIDTH 32 (address width); DATA_WIDTH 128 (cache line width); CYCLE_NUM_DATA 4 (data beats per line); BOUNDARY_UP 32'h0000_1FFF (highest legal address); BOUNDARY_LOW 32'h0000_0000 (lowest legal address).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  cache side offers a request.
REQ-005 req_ready  out  1  sender accepts a request this cycle.
REQ-006 req_op  in  2  request type: RD=00, WR=01, PWB=10; 11 is illegal.
REQ-007 req_addr  in  32  request address.
REQ-008 req_data  in  128  line data; used only for WR and PWB.
REQ-009 q_full  in  1  downstream memory queue is full.
REQ-010 q_push_en  out  1  push strobe to the queue.
REQ-011 q_op  out  2  op presented to the queue.
REQ-012 q_buf  out  38  request or data word presented to the queue.
REQ-013 sent_valid  out  1  one-cycle pulse when a request has been completely transmitted.
REQ-014 err_valid  out  1  one-cycle pulse when a request is rejected.
REQ-015 err_addr  out  32  address of the rejected request; holds until the next rejection.

Function
REQ-016 The FSM SHALL have the states IDLE, HDR, BEAT and GAP; req_ready SHALL equal (state==IDLE).
REQ-017 Acceptance SHALL occur when req_valid and req_ready are both high; op, addr and data SHALL be captured into internal registers.
REQ-018 An accepted request SHALL be rejected when addr > BOUNDARY_UP, addr < BOUNDARY_LOW, or op==11: err_valid=1 and err_addr=addr on the next cycle, state stays IDLE, nothing is pushed.
REQ-019 An accepted legal request SHALL move the FSM to HDR.
REQ-020 In HDR with q_full=0, the sender SHALL drive q_push_en=1, q_op=captured op, and q_buf={4'b0, op, addr}.
REQ-021 In HDR with q_full=1, the sender SHALL drive q_push_en=0 and q_op=00, and SHALL remain in HDR (stall, unbounded).
REQ-022 After the header is issued: RD -> IDLE with sent_valid=1 on the next cycle; WR/PWB -> BEAT with beat_cnt=0.
REQ-023 In BEAT, the sender SHALL drive q_push_en=1, q_op=captured op, and q_buf={4'b0, op, word}; word SHALL be data[127:96], [95:64], [63:32], [31:0] for beat_cnt 0..3.
REQ-024 The 4 beats SHALL be issued on consecutive cycles directly after the header; q_full SHALL be ignored during BEAT, and no gaps are permitted because the queue counts beats by cycle.
REQ-025 After beat 3, the FSM SHALL go to GAP for exactly one cycle (q_push_en=0, q_op=00), then to IDLE with sent_valid=1 on that transition; this covers the queue's dead cycle at data-counter 0.
REQ-026 In IDLE, HDR-stall and GAP, q_op SHALL be 00 and q_push_en SHALL be 0, so that a stray WR/PWB cannot arm the queue's receive state.
REQ-027 beat_cnt SHALL be 2 bits and wrap-free, since it is cleared when BEAT is entered.
REQ-028 Timing for WR accepted at cycle t with q_full=0: header at t+1, beats at t+2..t+5, GAP at t+6, req_ready high again at t+7. For RD: header at t+1, req_ready high at t+2.
REQ-029 Captured registers SHALL NOT change while state!=IDLE; req_data changes after acceptance SHALL have no effect.

Reset
REQ-030 On rst, the sender SHALL set state=IDLE, beat_cnt=0, q_push_en=0, q_op=00, q_buf=0, sent_valid=0, err_valid=0, err_addr=0; req_ready SHALL be 1 from the first cycle after reset.
REQ-031 rst asserted mid-burst SHALL abort the burst with no further beats; the queue SHALL share the same rst so that both ends restart together.

Structure
REQ-032 The op encodings (RD/WR/PWB), REQUEST_SIZE, DATA_WIDTH, CYCLE_NUM_DATA and the boundary constants SHALL live in the shared mem definitions package that the queue also uses.
REQ-033 The block SHALL be a single module with no sub-module; word selection SHALL be a 4-way mux inside it.

Verification
REQ-034 The bench SHALL cover: RD addr 0x0000_0040 with q_full=0 -> single push at t+1, q_buf=0x00_0000_0040, sent_valid at t+2.
REQ-035 The bench SHALL cover: WR addr 0x100, data 0x11111111_22222222_33333333_44444444 -> header, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles with q_op=01, one GAP cycle, then ready.
REQ-036 The bench SHALL cover: PWB with q_full=1 for 3 cycles -> q_push_en=0 and q_op=00 for 3 cycles, header on the 4th cycle, beats follow unbroken.
REQ-037 The bench SHALL cover: RD addr 0x0000_2000, then op=11 -> two err_valid pulses with err_addr 0x2000 then the offending address, no push.
REQ-038 The bench SHALL cover: rst asserted on beat 2 of a WR -> q_push_en=0 on the next cycle, IDLE, and a fresh RD is sent correctly afterwards.
REQ-039 The bench SHALL cover: back-to-back WR then RD via the real queue -> queue counter reaches 2, and pops return both entries with the WR line intact.
